// File: rtl/sys_ctrl_param_pkg.sv
// Shared definitions for sys_ctrl_param: command codes, FSM state enum and a sizing helper.
package sys_ctrl_param_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
    localparam logic [7:0] CMD_BURST   = 8'hEE;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_OPA,
        ST_OPB,
        ST_FUNC,
        ST_GATE,
        ST_ALU_WAIT,
        ST_TX_SEND,
        ST_BST_ADDR,
        ST_BST_CNT,
        ST_BST_RD
    } state_e;

    // Bits needed to hold a byte count from 0 up to and including n.
    function automatic int cnt_bits(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sys_ctrl_param_tx.sv
// tx_byte_serialiser: holds up to ALU_W bits and pushes them to the TX FIFO one byte at a time, LSB first.
module tx_byte_serialiser
    import sys_ctrl_param_pkg::*;
#(
    parameter int WIDTH_REG = 8,
    parameter int ALU_W     = 16,
    parameter int CW        = cnt_bits(ALU_W / WIDTH_REG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [ALU_W-1:0]     i_data,
    input  logic [CW-1:0]        i_count,
    input  logic                 i_tx_full,
    output logic [WIDTH_REG-1:0] o_tx_data,
    output logic                 o_tx_valid,
    output logic                 o_last
);

    logic [ALU_W-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // A push only happens in a cycle where the FIFO reports room; otherwise the byte is held.
    assign o_tx_valid = (cnt_q != '0) && !i_tx_full;
    assign o_tx_data  = shift_q[WIDTH_REG-1:0];
    assign o_last     = o_tx_valid && (cnt_q == CW'(1));

    always_comb begin
        // NOTE: every signal gets a default before the branches so no latch is inferred.
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (i_load) begin
            shift_d = i_data;
            cnt_d   = i_count;
        end else if (o_tx_valid) begin
            shift_d = shift_q >> WIDTH_REG;
            cnt_d   = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/sys_ctrl_param.sv
// Command controller: turns received UART frames into register-file, ALU and TX-FIFO transactions.
// Define SYS_CTRL_BURST_EN to compile in the 0xEE burst-read command and its BST_* states.
module sys_ctrl_param
    import sys_ctrl_param_pkg::*;
#(
    parameter int WIDTH_REG = 8,
    parameter int ADDR      = 4,
    parameter int fun       = 4,
    parameter int ALU_W     = 16
) (
    input  logic                 i_REF_CLK,
    input  logic                 i_RST,
    input  logic [WIDTH_REG-1:0] i_RX_DATA,
    input  logic                 i_RX_VALID,
    output logic [ADDR-1:0]      o_RF_ADDR,
    output logic                 o_RF_WR_EN,
    output logic [WIDTH_REG-1:0] o_RF_WR_DATA,
    output logic                 o_RF_RD_EN,
    input  logic [WIDTH_REG-1:0] i_RF_RD_DATA,
    input  logic                 i_RF_RD_VALID,
    output logic                 o_ALU_EN,
    output logic [fun-1:0]       o_ALU_FUN,
    output logic                 o_CLK_GATE_EN,
    input  logic [ALU_W-1:0]     i_ALU_OUT,
    input  logic                 i_ALU_VALID,
    output logic [WIDTH_REG-1:0] o_TX_DATA,
    output logic                 o_TX_VALID,
    input  logic                 i_TX_FULL,
    output logic                 o_CMD_ERR
);

    localparam int RES_BYTES = ALU_W / WIDTH_REG;
    localparam int CW        = cnt_bits(RES_BYTES);

    state_e               state_q, state_d;
    logic [ADDR-1:0]      rf_addr_q, rf_addr_d;
    logic [WIDTH_REG-1:0] wr_data_q, wr_data_d;
    logic [fun-1:0]       fun_q, fun_d;
    logic                 gate_q, gate_d;
    logic                 wr_en_q, wr_en_d;
    logic                 rd_en_q, rd_en_d;
    logic                 alu_en_q, alu_en_d;
    logic                 err_q, err_d;
`ifdef SYS_CTRL_BURST_EN
    logic [WIDTH_REG-1:0] cnt_q, cnt_d;
`endif

    logic                 ser_load, ser_last;
    logic [ALU_W-1:0]     ser_data;
    logic [CW-1:0]        ser_count;

    always_comb begin
        state_d   = state_q;
        rf_addr_d = rf_addr_q;
        wr_data_d = wr_data_q;
        fun_d     = fun_q;
        gate_d    = gate_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        err_d     = 1'b0;
        ser_load  = 1'b0;
        ser_data  = '0;
        ser_count = '0;
`ifdef SYS_CTRL_BURST_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: if (i_RX_VALID) begin
                if (i_RX_DATA == WIDTH_REG'(CMD_WR))           state_d = ST_WR_ADDR;
                else if (i_RX_DATA == WIDTH_REG'(CMD_RD))      state_d = ST_RD_ADDR;
                else if (i_RX_DATA == WIDTH_REG'(CMD_ALU_OP))  state_d = ST_OPA;
                else if (i_RX_DATA == WIDTH_REG'(CMD_ALU_NOP)) state_d = ST_FUNC;
`ifdef SYS_CTRL_BURST_EN
                else if (i_RX_DATA == WIDTH_REG'(CMD_BURST))   state_d = ST_BST_ADDR;
`endif
                else                                           err_d   = 1'b1;
            end
            ST_WR_ADDR: if (i_RX_VALID) begin
                rf_addr_d = i_RX_DATA[ADDR-1:0];
                state_d   = ST_WR_DATA;
            end
            ST_WR_DATA: if (i_RX_VALID) begin
                wr_data_d = i_RX_DATA;
                wr_en_d   = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_RD_ADDR: if (i_RX_VALID) begin
                rf_addr_d = i_RX_DATA[ADDR-1:0];
                rd_en_d   = 1'b1;
                state_d   = ST_RD_WAIT;
            end
            ST_RD_WAIT: if (i_RF_RD_VALID) begin
                ser_load  = 1'b1;
                ser_data  = ALU_W'(i_RF_RD_DATA);
                ser_count = CW'(1);
                state_d   = ST_TX_SEND;
            end
            // Operand frames land in the two fixed ALU operand registers.
            ST_OPA: if (i_RX_VALID) begin
                rf_addr_d = '0;
                wr_data_d = i_RX_DATA;
                wr_en_d   = 1'b1;
                state_d   = ST_OPB;
            end
            ST_OPB: if (i_RX_VALID) begin
                rf_addr_d = ADDR'(1);
                wr_data_d = i_RX_DATA;
                wr_en_d   = 1'b1;
                state_d   = ST_FUNC;
            end
            ST_FUNC: if (i_RX_VALID) begin
                fun_d   = i_RX_DATA[fun-1:0];
                gate_d  = 1'b1;
                state_d = ST_GATE;
            end
            // One cycle of gated clock before the start pulse lets the ALU clock settle.
            ST_GATE: begin
                alu_en_d = 1'b1;
                state_d  = ST_ALU_WAIT;
            end
            ST_ALU_WAIT: if (i_ALU_VALID) begin
                gate_d    = 1'b0;
                ser_load  = 1'b1;
                ser_data  = i_ALU_OUT;
                ser_count = CW'(RES_BYTES);
                state_d   = ST_TX_SEND;
            end
            ST_TX_SEND: if (ser_last) begin
`ifdef SYS_CTRL_BURST_EN
                if (cnt_q != '0) begin
                    rf_addr_d = rf_addr_q + ADDR'(1);
                    rd_en_d   = 1'b1;
                    state_d   = ST_BST_RD;
                end else begin
                    state_d   = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef SYS_CTRL_BURST_EN
            ST_BST_ADDR: if (i_RX_VALID) begin
                rf_addr_d = i_RX_DATA[ADDR-1:0];
                state_d   = ST_BST_CNT;
            end
            ST_BST_CNT: if (i_RX_VALID) begin
                cnt_d = i_RX_DATA;
                if (i_RX_DATA == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    rd_en_d = 1'b1;
                    state_d = ST_BST_RD;
                end
            end
            // cnt_q counts reads still to be issued, so it reaches zero on the final byte.
            ST_BST_RD: if (i_RF_RD_VALID) begin
                ser_load  = 1'b1;
                ser_data  = ALU_W'(i_RF_RD_DATA);
                ser_count = CW'(1);
                cnt_d     = cnt_q - WIDTH_REG'(1);
                state_d   = ST_TX_SEND;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (i_RX_VALID && (state_q inside {ST_RD_WAIT, ST_GATE, ST_ALU_WAIT, ST_TX_SEND, ST_BST_RD}))
            err_d = 1'b1;
    end

    always_ff @(posedge i_REF_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q   <= ST_IDLE;
            rf_addr_q <= '0;
            wr_data_q <= '0;
            fun_q     <= '0;
            gate_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            err_q     <= 1'b0;
`ifdef SYS_CTRL_BURST_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rf_addr_q <= rf_addr_d;
            wr_data_q <= wr_data_d;
            fun_q     <= fun_d;
            gate_q    <= gate_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            err_q     <= err_d;
`ifdef SYS_CTRL_BURST_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    tx_byte_serialiser #(
        .WIDTH_REG (WIDTH_REG),
        .ALU_W     (ALU_W),
        .CW        (CW)
    ) u_tx (
        .clk        (i_REF_CLK),
        .rst_n      (i_RST),
        .i_load     (ser_load),
        .i_data     (ser_data),
        .i_count    (ser_count),
        .i_tx_full  (i_TX_FULL),
        .o_tx_data  (o_TX_DATA),
        .o_tx_valid (o_TX_VALID),
        .o_last     (ser_last)
    );

    assign o_RF_ADDR     = rf_addr_q;
    assign o_RF_WR_EN    = wr_en_q;
    assign o_RF_WR_DATA  = wr_data_q;
    assign o_RF_RD_EN    = rd_en_q;
    assign o_ALU_EN      = alu_en_q;
    assign o_ALU_FUN     = fun_q;
    assign o_CLK_GATE_EN = gate_q;
    assign o_CMD_ERR     = err_q;

endmodule

// File: tb/tb_sys_ctrl_param.sv
// Scoreboard bench for sys_ctrl_param: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_sys_ctrl_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [3:0] rf_addr;
    logic       rf_wr_en, rf_rd_en;
    logic [7:0] rf_wr_data;
    logic [7:0] rd_data = '0;
    logic       rd_valid = 1'b0;
    logic       alu_en, gate_en, tx_valid, cmd_err;
    logic [3:0] alu_fun;
    logic [15:0] alu_out = '0;
    logic       alu_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_full = 1'b0;

    always #5 clk = ~clk;

    sys_ctrl_param #(.WIDTH_REG(8), .ADDR(4), .fun(4), .ALU_W(16)) dut (
        .i_REF_CLK     (clk),
        .i_RST         (rst_n),
        .i_RX_DATA     (rx_data),
        .i_RX_VALID    (rx_valid),
        .o_RF_ADDR     (rf_addr),
        .o_RF_WR_EN    (rf_wr_en),
        .o_RF_WR_DATA  (rf_wr_data),
        .o_RF_RD_EN    (rf_rd_en),
        .i_RF_RD_DATA  (rd_data),
        .i_RF_RD_VALID (rd_valid),
        .o_ALU_EN      (alu_en),
        .o_ALU_FUN     (alu_fun),
        .o_CLK_GATE_EN (gate_en),
        .i_ALU_OUT     (alu_out),
        .i_ALU_VALID   (alu_valid),
        .o_TX_DATA     (tx_data),
        .o_TX_VALID    (tx_valid),
        .i_TX_FULL     (tx_full),
        .o_CMD_ERR     (cmd_err)
    );

    typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;

    wr_t        exp_wr[$];
    logic [3:0] exp_rd[$];
    logic [7:0] exp_tx[$];
    logic [3:0] exp_fun[$];
    int         exp_err = 0;

    logic [7:0] mem_model[16];  // what the register file should hold
    logic [7:0] rf_mem[16];     // register file as the DUT actually wrote it

    int n_vec = 0;
    int n_err = 0;
    int full_hold = 0;
    bit rand_full = 1'b0;
    int alu_delay = 0;
    bit alu_abort = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: DUT produced an event, none expected", name);
    endtask

    // Monitor: every DUT strobe must match the head of its expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rf_wr_en) begin
                rf_mem[rf_addr] = rf_wr_data;
                if (exp_wr.size() == 0) flag("rf_write");
                else check("rf_write", 32'({rf_addr, rf_wr_data}), 32'(exp_wr.pop_front()));
            end
            if (rf_rd_en) begin
                if (exp_rd.size() == 0) flag("rf_read");
                else check("rf_read_addr", 32'(rf_addr), 32'(exp_rd.pop_front()));
            end
            if (tx_valid) begin
                check("tx_while_full", 32'(tx_full), 32'(0));
                if (exp_tx.size() == 0) flag("tx_push");
                else check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
            if (alu_en) begin
                check("gate_at_alu_en", 32'(gate_en), 32'(1));
                if (exp_fun.size() == 0) flag("alu_start");
                else check("alu_fun", 32'(alu_fun), 32'(exp_fun.pop_front()));
            end
            if (cmd_err) begin
                check("cmd_err_expected", 32'(exp_err > 0), 32'(1));
                if (exp_err > 0) exp_err--;
            end
        end
    end

    // TX FIFO full pattern: forced high for full_hold cycles, otherwise optionally random.
    initial forever begin
        @(posedge clk); #1;
        if (full_hold > 0) begin
            tx_full = 1'b1;
            full_hold--;
        end else begin
            tx_full = rand_full && ($urandom_range(0, 3) == 0);
        end
    end

    // Register-file responder.
    initial begin : rf_resp
        logic [3:0] ra;
        forever begin
            @(negedge clk);
            if (rst_n && rf_rd_en) begin
                ra = rf_addr;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                @(posedge clk); #1;
                rd_data  = rf_mem[ra];
                rd_valid = 1'b1;
                @(posedge clk); #1;
                rd_valid = 1'b0;
                rd_data  = 8'($urandom);
                @(negedge clk);
                if (rst_n && !tx_full) check("rd_valid_to_tx", 32'(tx_valid), 32'(1));
            end
        end
    end

    // ALU responder: returns alu_out after alu_delay cycles and checks the gate around it.
    initial begin : alu_resp
        bit skip;
        forever begin
            @(negedge clk);
            if (rst_n && alu_en) begin
                skip = alu_abort;
                repeat (alu_delay) @(posedge clk);
                @(posedge clk); #1;
                alu_valid = 1'b1;
                @(negedge clk);
                if (!skip) check("gate_before_valid", 32'(gate_en), 32'(1));
                @(posedge clk); #1;
                alu_valid = 1'b0;
                @(negedge clk);
                if (!skip) check("gate_after_valid", 32'(gate_en), 32'(0));
                alu_abort = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    function automatic bit pending();
        return exp_wr.size() != 0 || exp_rd.size() != 0 || exp_tx.size() != 0 ||
               exp_fun.size() != 0 || exp_err != 0;
    endfunction

    task automatic drain();
        int t = 0;
        while (pending() && t < 300) begin idle(1); t++; end
        if (pending()) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d tx, %0d rd, %0d wr, %0d errs still expected",
                     exp_tx.size(), exp_rd.size(), exp_wr.size(), exp_err);
            exp_wr.delete(); exp_rd.delete(); exp_tx.delete(); exp_fun.delete(); exp_err = 0;
        end
        idle(3);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        exp_wr.push_back('{a: a, d: d});
        mem_model[a] = d;
        send(8'hAA);
        send({4'($urandom), a});
        send(d);
        @(negedge clk);
        check("wr_en_latency", 32'(rf_wr_en), 32'(1));
        @(posedge clk); #1;
        drain();
    endtask

    task automatic do_read(input logic [3:0] a);
        exp_rd.push_back(a);
        exp_tx.push_back(mem_model[a]);
        send(8'hBB);
        send({4'($urandom), a});
        @(negedge clk);
        check("rd_en_latency", 32'(rf_rd_en), 32'(1));
        @(posedge clk); #1;
        drain();
    endtask

    task automatic do_alu(input bit ops, input logic [7:0] opa, input logic [7:0] opb,
                          input logic [3:0] f, input logic [15:0] res, input bit hold, input bit drop);
        if (ops) begin
            exp_wr.push_back('{a: 4'd0, d: opa});
            exp_wr.push_back('{a: 4'd1, d: opb});
            mem_model[0] = opa;
            mem_model[1] = opb;
            send(8'hCC);
            send(opa);
            send(opb);
        end else begin
            send(8'hDD);
        end
        alu_out = res;
        exp_fun.push_back(f);
        exp_tx.push_back(res[7:0]);
        exp_tx.push_back(res[15:8]);
        send({4'($urandom), f});
        @(negedge clk);
        check("gate_rise", 32'(gate_en), 32'(1));
        check("alu_en_not_yet", 32'(alu_en), 32'(0));
        if (hold) full_hold = 5;
        @(negedge clk);
        check("alu_en_follow", 32'(alu_en), 32'(1));
        @(posedge clk); #1;
        if (drop) begin
            idle(2);
            exp_err++;
            send(8'h33);
        end
        drain();
    endtask

    task automatic do_bad();
        logic [7:0] b;
        b = 8'($urandom);
`ifdef SYS_CTRL_BURST_EN
        while (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE}) b = 8'($urandom);
`else
        while (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) b = 8'($urandom);
`endif
        exp_err++;
        send(b);
        drain();
    endtask

`ifdef SYS_CTRL_BURST_EN
    task automatic do_burst(input logic [3:0] a, input logic [7:0] n);
        for (int i = 0; i < int'(n); i++) begin
            exp_rd.push_back(4'(int'(a) + i));
            exp_tx.push_back(mem_model[4'(int'(a) + i)]);
        end
        send(8'hEE);
        send({4'($urandom), a});
        send(n);
        drain();
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_model[i] = 8'($urandom);
            rf_mem[i]    = mem_model[i];
        end
        idle(2);
        check("reset_outputs", 32'({rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_en, alu_fun,
                                    gate_en, tx_data, tx_valid, cmd_err}), 32'(0));
        rst_n = 1'b1;
        idle(2);

        do_write(4'd4, 8'h55);
        do_read(4'd4);
        do_alu(1'b1, 8'd20, 8'd10, 4'h2, 16'd200, 1'b0, 1'b0);
        do_alu(1'b0, 8'h00, 8'h00, 4'h1, 16'h000A, 1'b1, 1'b0);
        exp_err++;
        send(8'h7F);
        drain();
`ifdef SYS_CTRL_BURST_EN
        do_burst(4'hE, 8'd3);
        do_burst(4'h3, 8'd0);
`else
        exp_err++;
        send(8'hEE);
        drain();
`endif

        // A frame arriving while the ALU is busy is dropped with an error pulse.
        alu_delay = 8;
        do_alu(1'b0, 8'h00, 8'h00, 4'h7, 16'h1234, 1'b0, 1'b1);
        alu_delay = 0;

        // Stray valids while idle must produce nothing.
        rd_valid  = 1'b1;
        alu_valid = 1'b1;
        idle(1);
        rd_valid  = 1'b0;
        alu_valid = 1'b0;
        drain();

        // Reset while waiting on the ALU.
        alu_delay = 30;
        alu_abort = 1'b1;
        exp_fun.push_back(4'h3);
        alu_out = 16'hBEEF;
        send(8'hDD);
        send(8'h03);
        idle(4);
        check("gate_in_alu_wait", 32'(gate_en), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 32'({rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_en, alu_fun,
                                    gate_en, tx_data, tx_valid, cmd_err}), 32'(0));
        @(posedge clk); #1;
        idle(2);
        rst_n = 1'b1;
        idle(40);
        check("post_abort_gate", 32'(gate_en), 32'(0));
        alu_delay = 0;

        rand_full = 1'b1;
        for (int it = 0; it < 40; it++) begin
            alu_delay = $urandom_range(0, 3);
            case ($urandom_range(0, 5))
                0: do_write(4'($urandom), 8'($urandom));
                1: do_read(4'($urandom));
                2: do_alu(1'b1, 8'($urandom), 8'($urandom), 4'($urandom), 16'($urandom), 1'b0, 1'b0);
                3: do_alu(1'b0, 8'h00, 8'h00, 4'($urandom), 16'($urandom), 1'b0, 1'b0);
                4: do_bad();
                default: begin
`ifdef SYS_CTRL_BURST_EN
                    do_burst(4'($urandom), 8'($urandom_range(0, 4)));
`else
                    exp_err++;
                    send(8'hEE);
                    drain();
`endif
                end
            endcase
        end
        rand_full = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
